// File: rtl/mips32_dmem_responder_if.sv
// Request/response channel between the MIPS32 load/store unit and its data memory.
// The core drives through the master modport; the memory responder uses slave.
interface mips32_dmem_responder_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mips32_dmem_responder.sv
// Word-addressed data memory for the MIPS32 core with programmable wait states,
// one outstanding request, and error responses for out-of-range addresses.
module mips32_dmem_responder #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                          clk_1,
  input  logic                          rst,
  mips32_dmem_responder_if.slave        bus,
  output logic [7:0]                    err_count
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic          in_range;
  logic [IdxW-1:0] idx;

  // Full-width compare: high address bits never alias onto the array.
  assign in_range = (addr_q < AW'(DEPTH));
  assign idx      = addr_q[IdxW-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_we    = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.req_valid && ready_q) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 8'(WAIT_CYCLES);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 8'd0) begin
          state_d = StResp;
          valid_d = 1'b1;
          if (in_range) begin
            mem_we  = we_q;
            rdata_d = we_q ? '0 : mem[idx];
            err_d   = 1'b0;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so req_ready stays low through reset and the handshake edge.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Array has no reset; contents survive rst.
  always_ff @(posedge clk_1) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// Directed bench: a WAIT_CYCLES=2 responder driven from a vector table and
// hand-written corner sequences, plus a WAIT_CYCLES=0 instance for latency.
module tb_mips32_dmem_responder;

  localparam int unsigned Wait2 = 2;

  logic       clk_1;
  logic       rst;
  logic [7:0] err_count0;
  logic [7:0] err_count1;

  int checks;
  int errors;

  mips32_dmem_responder_if #(.AW(32), .DW(32)) bus0 ();
  mips32_dmem_responder_if #(.AW(32), .DW(32)) bus1 ();

  mips32_dmem_responder #(.WAIT_CYCLES(Wait2)) dut (
    .clk_1     (clk_1),
    .rst       (rst),
    .bus       (bus0),
    .err_count (err_count0)
  );

  mips32_dmem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk_1     (clk_1),
    .rst       (rst),
    .bus       (bus1),
    .err_count (err_count1)
  );

  initial begin
    clk_1 = 1'b0;
    forever #5 clk_1 = ~clk_1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  // Present a request on bus0, wait for accept, then for rsp_valid. Returns
  // the number of edges from accept to rsp_valid; rsp_ready is left as given.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rdy, input string name, output int lat);
    int n;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    bus0.req_valid = 1'b1;
    bus0.rsp_ready = rdy;
    lat = -1;
    n = 0;
    while (!bus0.req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus0.req_ready) begin
      check({name, " accept timeout"}, 32'd0, 32'd1);
      bus0.req_valid = 1'b0;
      return;
    end
    tick();
    bus0.req_valid = 1'b0;
    n = 0;
    while (!bus0.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus0.rsp_valid) check({name, " rsp timeout"}, 32'd0, 32'd1);
    lat = n;
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input string name);
    int lat;
    issue(we, addr, wdata, 1'b1, name, lat);
    check({name, " latency"}, lat, Wait2 + 1);
    check({name, " rdata"}, bus0.rsp_rdata, exp_rdata);
    check({name, " err"}, {31'd0, bus0.rsp_err}, {31'd0, exp_err});
    tick();
    check({name, " valid drop"}, {31'd0, bus0.rsp_valid}, 32'd0);
    check({name, " ready back"}, {31'd0, bus0.req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;

    vecs[0] = '{1'b1, 32'd5,          32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 32'd0,          32'h11111111, 32'h0,        1'b0};
    vecs[3] = '{1'b1, 32'd512,        32'h00001234, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 32'd0,          32'h0,        32'h11111111, 1'b0};
    vecs[5] = '{1'b1, 32'd511,        32'hCAFEF00D, 32'h0,        1'b0};
    vecs[6] = '{1'b0, 32'd511,        32'h0,        32'hCAFEF00D, 1'b0};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'h0,        32'h0,        1'b1};
    vecs[8] = '{1'b0, 32'd517,        32'h0,        32'h0,        1'b1};
    vecs[9] = '{1'b1, 32'd7,          32'h00000077, 32'h0,        1'b0};

    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.rsp_ready = 1'b0;

    // Reset: req_ready low while rst is low and until the first edge after release.
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst req_ready", {31'd0, bus0.req_ready}, 32'd0);
    check("rst rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    check("rst err_count", {24'd0, err_count0}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("post-rst ready before edge", {31'd0, bus0.req_ready}, 32'd0);
    tick();
    check("idle req_ready", {31'd0, bus0.req_ready}, 32'd1);
    check("idle rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    check("idle rsp_rdata", bus0.rsp_rdata, 32'd0);
    check("idle err_count", {24'd0, err_count0}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err,
              $sformatf("vec%0d", i));
    end
    check("err_count after vectors", {24'd0, err_count0}, 32'd3);

    // Back-pressure: response must hold while a second request waits unaccepted.
    issue(1'b0, 32'd5, 32'h0, 1'b0, "bp", lat);
    bus0.req_we = 1'b0; bus0.req_addr = 32'd0; bus0.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp valid c%0d", i), {31'd0, bus0.rsp_valid}, 32'd1);
      check($sformatf("bp rdata c%0d", i), bus0.rsp_rdata, 32'hDEADBEEF);
      check($sformatf("bp ready c%0d", i), {31'd0, bus0.req_ready}, 32'd0);
    end
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    tick();
    check("bp handshake valid", {31'd0, bus0.rsp_valid}, 32'd0);
    check("bp handshake ready", {31'd0, bus0.req_ready}, 32'd1);

    // Reset while holding an error response in RESP.
    issue(1'b0, 32'd600, 32'h0, 1'b0, "rresp", lat);
    check("rresp err", {31'd0, bus0.rsp_err}, 32'd1);
    check("rresp err_count", {24'd0, err_count0}, 32'd4);
    rst = 1'b0;
    #1;
    check("rresp valid cleared", {31'd0, bus0.rsp_valid}, 32'd0);
    check("rresp err cleared", {31'd0, bus0.rsp_err}, 32'd0);
    check("rresp count cleared", {24'd0, err_count0}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Reset during BUSY of a store: the write must not happen.
    bus0.req_we = 1'b1; bus0.req_addr = 32'd7; bus0.req_wdata = 32'hAA;
    bus0.req_valid = 1'b1; bus0.rsp_ready = 1'b1;
    check("mid ready", {31'd0, bus0.req_ready}, 32'd1);
    tick();
    bus0.req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("mid rst valid", {31'd0, bus0.rsp_valid}, 32'd0);
    check("mid rst ready", {31'd0, bus0.req_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    run_req(1'b0, 32'd7, 32'h0, 32'h00000077, 1'b0, "mid load7");

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      run_req(1'b0, 32'd1000 + i, 32'h0, 32'h0, 1'b1, "sat");
    end
    check("err_count saturated", {24'd0, err_count0}, 32'd255);

    // WAIT_CYCLES=0 instance: response one edge after accept; a held request
    // is re-accepted right after the handshake edge.
    bus1.req_we = 1'b1; bus1.req_addr = 32'd3; bus1.req_wdata = 32'h55;
    bus1.req_valid = 1'b1; bus1.rsp_ready = 1'b1;
    check("w0 ready", {31'd0, bus1.req_ready}, 32'd1);
    tick();
    bus1.req_we = 1'b0; bus1.req_wdata = 32'h0;
    check("w0 T valid", {31'd0, bus1.rsp_valid}, 32'd0);
    check("w0 T ready", {31'd0, bus1.req_ready}, 32'd0);
    tick();
    check("w0 T+1 valid", {31'd0, bus1.rsp_valid}, 32'd1);
    check("w0 T+1 rdata", bus1.rsp_rdata, 32'd0);
    tick();
    check("w0 T+2 valid", {31'd0, bus1.rsp_valid}, 32'd0);
    check("w0 T+2 ready", {31'd0, bus1.req_ready}, 32'd1);
    tick();
    bus1.req_valid = 1'b0;
    check("w0 T+3 accepted", {31'd0, bus1.req_ready}, 32'd0);
    tick();
    check("w0 load valid", {31'd0, bus1.rsp_valid}, 32'd1);
    check("w0 load rdata", bus1.rsp_rdata, 32'h55);
    check("w0 load err", {31'd0, bus1.rsp_err}, 32'd0);
    tick();
    check("w0 load done", {31'd0, bus1.rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
